pcileech_btn_rst_ctl: RTL

//  Board button/reset conditioning stage feeding the board top: syncs + debounces user_sw1_n/user_sw2_n,

---
 rtl/pcileech_btn_rst_ctl_pkg.sv | 4 +
 rtl/pcileech_btn_debounce.sv | 36 +++
 rtl/pcileech_btn_rst_ctl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pcileech_btn_rst_ctl_pkg.sv
// pcileech_btn_rst_ctl_pkg: shared state encoding for the button/reset controller
package pcileech_btn_rst_ctl_pkg;
    typedef enum logic [1:0] {S_POR, S_RUN, S_HOLD, S_RELOAD} rstctl_state_t;
endpackage

// File: rtl/pcileech_btn_debounce.sv
// pcileech_btn_debounce: 2-FF synchronizer plus stable-count debounce for one raw button pin
module pcileech_btn_debounce
    import pcileech_btn_rst_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din_async,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          sync1_q, sync2_q, dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, done;
    always_comb begin
        differ = sync2_q != dout_q;
        done   = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d  = (!differ || done) ? '0 : cnt_q + CW'(1);
        dout_d = (differ && done) ? sync2_q : dout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dout_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_async;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end
    assign dout = dout_q;
endmodule

// File: rtl/pcileech_btn_rst_ctl.sv
// pcileech_btn_rst_ctl: button conditioning, system reset / config-reload sequencing, tick counter and power-on blink
module pcileech_btn_rst_ctl
    import pcileech_btn_rst_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int POR_CYCLES      = 64,
    parameter int RELOAD_CYCLES   = 500_000_000,
    parameter int BLINK_BIT       = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        user_sw1_n,
    input  logic        user_sw2_n,
    output logic        rst_sys,
    output logic        rst_cfg_reload,
    output logic        ft2232_rst_n,
    output logic        led_pwronblink,
    output logic [63:0] tickcount64
);
    localparam int PW = $clog2(POR_CYCLES);
    localparam int HW = $clog2(RELOAD_CYCLES + 1);
    rstctl_state_t state_q, state_d;
    logic [PW-1:0] por_cnt_q, por_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [63:0]   tick_q, tick_d;
    logic          rst_sys_q, rst_sys_d, reload_q, reload_d, ft_q, ft_d, led_q, led_d;
    logic          sw1_db, sw2_db, sw1_pressed, sw2_pressed, holding;
    pcileech_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw1 (
        .clk(clk), .rst(rst), .din_async(user_sw1_n), .dout(sw1_db)
    );
    pcileech_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw2 (
        .clk(clk), .rst(rst), .din_async(user_sw2_n), .dout(sw2_db)
    );
    assign sw1_pressed = ~sw1_db;
    assign sw2_pressed = ~sw2_db;
    always_comb begin
        state_d    = state_q;
        por_cnt_d  = por_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_POR: begin
                por_cnt_d = por_cnt_q + PW'(1);
                if (sw2_pressed) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end else if (por_cnt_q == PW'(POR_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sw2_pressed) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (!sw2_pressed) begin
                    state_d   = S_POR;
                    por_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                    if (hold_cnt_q == HW'(RELOAD_CYCLES - 1)) state_d = S_RELOAD;
                end
            end
            default: begin
                if (!sw2_pressed) begin
                    state_d   = S_POR;
                    por_cnt_d = '0;
                end
            end
        endcase
        // outputs decode the next state so they move on the same edge as the FSM
        holding   = state_d == S_HOLD || state_d == S_RELOAD;
        tick_d    = holding ? '0 : tick_q + 64'd1;
        rst_sys_d = state_d != S_RUN;
        reload_d  = state_d == S_RELOAD;
        ft_d      = !holding;
        led_d     = sw1_pressed ^ (tick_q[BLINK_BIT] & (tick_q[63:BLINK_BIT+3] == '0));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_POR;
            por_cnt_q  <= '0;
            hold_cnt_q <= '0;
            tick_q     <= '0;
            rst_sys_q  <= 1'b1;
            reload_q   <= 1'b0;
            ft_q       <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            por_cnt_q  <= por_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            tick_q     <= tick_d;
            rst_sys_q  <= rst_sys_d;
            reload_q   <= reload_d;
            ft_q       <= ft_d;
            led_q      <= led_d;
        end
    end
    assign rst_sys        = rst_sys_q;
    assign rst_cfg_reload = reload_q;
    assign ft2232_rst_n   = ft_q;
    assign led_pwronblink = led_q;
    assign tickcount64    = tick_q;
endmodule
